// File: rtl/clk_div_pkg.sv
// Shared types and parameter defaults for the divided-clock monitor.
package clk_div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StLocked,
        StLost
    } state_e;

    localparam int unsigned CNT_W_DEF       = 8;
    localparam int unsigned LOCK_CNT_DEF    = 4;
    localparam int unsigned TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/clk_edge_detect.sv
// Registers the divided-clock level and flags its rising/falling edges.
module clk_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_level,
    output logic o_rise,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    logic r_d_q;
    logic r_rise_tick;
    logic r_fall_tick;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_d_q       <= 1'b0;
            r_rise_tick <= 1'b0;
            r_fall_tick <= 1'b0;
        end else begin
            r_d_q       <= i_level;
            r_rise_tick <= i_level & ~r_d_q;
            r_fall_tick <= ~i_level & r_d_q;
        end
    end

    // Unregistered rise qualifier consumed by the counter/FSM on this same edge.
    assign o_rise      = i_level & ~r_d_q;
    assign o_rise_tick = r_rise_tick;
    assign o_fall_tick = r_fall_tick;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the rise-to-rise period of a divided clock and tracks lock and loss
// of that clock against a reference period captured after the first edge.
module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned LOCK_CNT    = LOCK_CNT_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_clk_in,
    input  logic             clear,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    localparam int unsigned      STB_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT_CYC);
    localparam logic [STB_W-1:0] STB_LOCK = STB_W'(LOCK_CNT);

    logic w_rise;
    logic w_soft_rst;
    logic w_match;

    state_e           r_state,        w_state_d;
    logic [CNT_W-1:0] r_cnt,          w_cnt_d;
    logic [CNT_W-1:0] r_period,       w_period_d;
    logic             r_period_valid, w_period_valid_d;
    logic [CNT_W-1:0] r_ref_period,   w_ref_period_d;
    logic [STB_W-1:0] r_stable,       w_stable_d;
    logic             r_first,        w_first_d;

    clk_edge_detect u_edge (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_level     (div_clk_in),
        .o_rise      (w_rise),
        .o_rise_tick (rise_tick),
        .o_fall_tick (fall_tick)
    );

    // Soft clear resets everything except the edge detector history.
    assign w_soft_rst = reset | clear;
    assign w_match    = (r_cnt == r_ref_period);

    always_ff @(posedge clk) begin
        if (w_soft_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d        = r_state;
        w_cnt_d          = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        w_period_d       = r_period;
        w_period_valid_d = 1'b0;
        w_ref_period_d   = r_ref_period;
        w_stable_d       = r_stable;
        w_first_d        = r_first;

        if (w_rise) begin
            w_cnt_d = CNT_W'(1);
        end

        unique case (r_state)
            StIdle, StLost: begin
                if (w_rise) begin
                    w_state_d  = StMeasure;
                    w_stable_d = '0;
                    w_first_d  = 1'b1;
                end
            end
            StMeasure: begin
                if (w_rise) begin
                    w_period_d       = r_cnt;
                    w_period_valid_d = 1'b1;
                    if (r_first) begin
                        w_ref_period_d = r_cnt;
                        w_first_d      = 1'b0;
                    end else if (w_match) begin
                        w_stable_d = r_stable + STB_W'(1);
                        if (w_stable_d == STB_LOCK) begin
                            w_state_d = StLocked;
                        end
                    end else begin
                        w_stable_d = '0;
                    end
                end else if (r_cnt == CNT_TO) begin
                    w_state_d = StLost;
                end
            end
            StLocked: begin
                if (w_rise) begin
                    w_period_d       = r_cnt;
                    w_period_valid_d = 1'b1;
                    if (!w_match) begin
                        w_state_d  = StMeasure;
                        w_stable_d = '0;
                    end
                end else if (r_cnt == CNT_TO) begin
                    w_state_d = StLost;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        locked = (r_state == StLocked);
        lost   = (r_state == StLost);
    end

    always_ff @(posedge clk) begin
        if (w_soft_rst) begin
            r_cnt          <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_ref_period   <= '0;
            r_stable       <= '0;
            r_first        <= 1'b1;
        end else begin
            r_cnt          <= w_cnt_d;
            r_period       <= w_period_d;
            r_period_valid <= w_period_valid_d;
            r_ref_period   <= w_ref_period_d;
            r_stable       <= w_stable_d;
            r_first        <= w_first_d;
        end
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor; reported periods are checked against a queue.
module tb_clk_div_monitor;

    logic       clk;
    logic       reset;
    logic       div_clk_in;
    logic       clear;
    logic       rise_tick;
    logic       fall_tick;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       lost;

    int          n_tests;
    int          n_fail;
    int          prev_k;
    int unsigned sb_q[$];

    clk_div_monitor #(
        .CNT_W       (8),
        .LOCK_CNT    (4),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .div_clk_in   (div_clk_in),
        .clear        (clear),
        .rise_tick    (rise_tick),
        .fall_tick    (fall_tick),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic step(input logic lvl);
        div_clk_in = lvl;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One period of k cycles: 2 high, k-2 low. The rise reports the previous gap.
    task automatic wave(input int k, input bit pv);
        if (pv) sb_q.push_back(prev_k);
        step(1'b1);
        check("rise_tick", {31'd0, rise_tick}, 1);
        check("period_valid_at_rise", {31'd0, period_valid}, {31'd0, pv});
        step(1'b1);
        check("rise_tick_single", {31'd0, rise_tick}, 0);
        step(1'b0);
        check("fall_tick", {31'd0, fall_tick}, 1);
        for (int i = 3; i < k; i++) step(1'b0);
        prev_k = k;
    endtask

    task automatic lock_seq();
        wave(4, 1'b0);
        for (int i = 0; i < 4; i++) wave(4, 1'b1);
        check("not_locked_5th_rise", {31'd0, locked}, 0);
        wave(4, 1'b1);
        check("locked_6th_rise", {31'd0, locked}, 1);
    endtask

    task automatic relock4();
        for (int i = 0; i < 3; i++) wave(4, 1'b1);
        check("relock_pending", {31'd0, locked}, 0);
        wave(4, 1'b1);
        check("relocked", {31'd0, locked}, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rise_tick"}, {31'd0, rise_tick}, 0);
        check({tag, "_fall_tick"}, {31'd0, fall_tick}, 0);
        check({tag, "_period"}, {24'd0, period}, 0);
        check({tag, "_period_valid"}, {31'd0, period_valid}, 0);
        check({tag, "_locked"}, {31'd0, locked}, 0);
        check({tag, "_lost"}, {31'd0, lost}, 0);
    endtask

    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            check("sb_expected_pulse", {31'd0, sb_q.size() > 0}, 1);
            if (sb_q.size() > 0) check("sb_period", {24'd0, period}, sb_q.pop_front());
        end
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        prev_k     = 0;
        reset      = 1'b1;
        clear      = 1'b0;
        div_clk_in = 1'b0;
        step(1'b0);
        step(1'b0);
        check_reset_vals("reset");
        reset = 1'b0;
        step(1'b0);
        step(1'b0);

        // Divide-by-4 from reset: lock at the 6th rise.
        lock_seq();
        check("period_div4", {24'd0, period}, 4);

        // Held low: lost exactly 64 cycles after the last rise.
        for (int i = 0; i < 60; i++) step(1'b0);
        check("lost_before_timeout", {31'd0, lost}, 0);
        check("locked_before_timeout", {31'd0, locked}, 1);
        step(1'b0);
        check("lost_at_timeout", {31'd0, lost}, 1);
        check("locked_drop_at_timeout", {31'd0, locked}, 0);

        // Recover from LOST, then insert one period of 6.
        lock_seq();
        check("lost_cleared", {31'd0, lost}, 0);
        wave(6, 1'b1);
        check("locked_before_mismatch", {31'd0, locked}, 1);
        wave(4, 1'b1);
        check("unlocked_on_mismatch", {31'd0, locked}, 0);
        check("period_6", {24'd0, period}, 6);
        relock4();

        // Rise exactly at the timeout count wins over LOST.
        wave(64, 1'b1);
        check("no_lost_long_period", {31'd0, lost}, 0);
        wave(4, 1'b1);
        check("no_lost_at_boundary", {31'd0, lost}, 0);
        check("period_64", {24'd0, period}, 64);
        relock4();

        // Clear while locked with the input high.
        sb_q.push_back(prev_k);
        step(1'b1);
        step(1'b1);
        clear = 1'b1;
        step(1'b1);
        clear = 1'b0;
        check("clear_locked", {31'd0, locked}, 0);
        check("clear_lost", {31'd0, lost}, 0);
        check("clear_period", {24'd0, period}, 0);
        check("clear_period_valid", {31'd0, period_valid}, 0);
        step(1'b1);
        check("clear_no_spurious_rise", {31'd0, rise_tick}, 0);
        step(1'b0);
        step(1'b0);
        wave(4, 1'b0);
        check("clear_then_measure", {31'd0, locked}, 0);

        // One-cycle reset mid-stream, landing on a high phase.
        wave(4, 1'b1);
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        check_reset_vals("midreset");
        lock_seq();

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
